// File: rtl/la_iocfg_chain_pkg.sv
// Shared padring config definitions: state encoding for the serial pad
// config chain controllers.
package la_iocfg_chain_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_WAIT   = WAIT,
    ST_SHIFT  = SHIFT,
    ST_UPDATE = UPDATE
  } iocfg_state_e;

endpackage

// File: rtl/la_iocfg_piso.sv
// Parallel-in/serial-out register for one pad config word, LSB first.
// Zeros shift in, so after a full word the register and serial output idle at 0.
module la_iocfg_piso #(
  parameter int CFGW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [CFGW-1:0] din,
  output logic            sdo
);

  logic [CFGW-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst)
      sreg <= '0;
    else if (load)
      sreg <= din;
    else if (shift)
      sreg <= sreg >> 1;
  end

  assign sdo = sreg[0];

endmodule

// File: rtl/la_iocfg_chain.sv
// Padring config chain loader: serialises a frame of NPADS config words into
// the pad chain, then strobes the update latch.
//
// state     | meaning
// IDLE      | no frame in progress, ready for the first word
// WAIT      | mid-frame, waiting for the next word
// SHIFT     | shifting one word into the chain (CFGW cycles)
// UPDATE    | frame complete, chain_upd held for UPDW cycles
module la_iocfg_chain
  import la_iocfg_chain_pkg::*;
#(
  parameter int NPADS = 8,
  parameter int CFGW  = 8,
  parameter int UPDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CFGW-1:0] in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            chain_sdo,
  output logic            chain_en,
  output logic            chain_upd,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int BCW = $clog2(CFGW + 1);
  localparam int WCW = $clog2(NPADS + 1);
  localparam int UCW = $clog2(UPDW + 1);

  localparam logic [BCW-1:0] BIT_LAST   = BCW'(CFGW - 1);
  localparam logic [WCW-1:0] WORD_FULL  = WCW'(NPADS);
  localparam logic [UCW-1:0] UPD_LAST   = UCW'(UPDW - 1);

  iocfg_state_e   state;
  logic [BCW-1:0] bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic [UCW-1:0] upd_cnt;
  logic           last_q;

  assign in_ready  = (state == ST_IDLE) || (state == ST_WAIT);
  assign chain_en  = (state == ST_SHIFT);
  assign chain_upd = (state == ST_UPDATE);
  assign busy      = (state != ST_IDLE);

  la_iocfg_piso #(.CFGW(CFGW)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (in_valid & in_ready),
    .shift (chain_en),
    .din   (in_data),
    .sdo   (chain_sdo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
      upd_cnt  <= '0;
      last_q   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (in_valid) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
            last_q  <= in_last;
            // A word taken in IDLE always opens a new frame.
            if (state == ST_IDLE) begin
              word_cnt <= WCW'(1);
              err      <= 1'b0;
            end else if (word_cnt != WORD_FULL) begin
              word_cnt <= word_cnt + WCW'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if ((word_cnt < WORD_FULL) && !last_q) begin
              state <= ST_WAIT;
            end else if ((word_cnt == WORD_FULL) && last_q) begin
              state <= ST_UPDATE;
            end else begin
              state <= ST_IDLE;
              err   <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        ST_UPDATE: begin
          if (upd_cnt == UPD_LAST) begin
            upd_cnt <= '0;
            state   <= ST_IDLE;
            done    <= 1'b1;
          end else begin
            upd_cnt <= upd_cnt + UCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
